wb_vram_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter in front of the VRAM/memory slave.
- Master 0 is the video line-fetch cache (read-only, cyc==stb, long back-to-back bursts). Master 1 is the CPU data port.
- Grants one master at a time and holds the grant for the whole cyc. Routes address, data and select to the slave; routes terminations back to the granted master only.
- A watchdog turns a hung slave access into an error termination, so display fetch cannot deadlock the bus.

---
 rtl/wb_vram_arbiter_pkg.sv | 18 +
 rtl/wb_vram_arbiter_if.sv | 30 +++
 rtl/wb_vram_arbiter_watchdog.sv | 43 ++++
 rtl/wb_vram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_vram_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: state encoding, default widths and
// the default VRAM base address.
package wb_vram_arbiter_pkg;

    localparam int unsigned ARB_ADR_W   = 32;
    localparam int unsigned ARB_DAT_W   = 32;
    localparam int unsigned ARB_TIMEOUT = 255;

    // Default VRAM window base, used by benches to address the frame buffer.
    localparam logic [31:0] VRAM_BASE = 32'h00f8_0000;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_vram_arbiter_if.sv
// Wishbone bus bundle: request side (cyc/stb/we/adr/sel/dat_w) flows from
// master to slave, response side (dat_r/ack/err/rty) flows back.
interface wb_vram_arbiter_if
    import wb_vram_arbiter_pkg::*;
#(
    parameter int unsigned ADR_W = ARB_ADR_W,
    parameter int unsigned DAT_W = ARB_DAT_W
);
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [ADR_W-1:0]     adr;
    logic [DAT_W/8-1:0]   sel;
    logic [DAT_W-1:0]     dat_w;
    logic [DAT_W-1:0]     dat_r;
    logic                 ack;
    logic                 err;
    logic                 rty;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, err, rty
    );

endinterface

// File: rtl/wb_vram_arbiter_watchdog.sv
// Strobe watchdog: counts unterminated strobe cycles and fires a one-cycle
// pulse when a slave access has hung for TIMEOUT cycles.
module wb_watchdog
    import wb_vram_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic active,
    input  logic term,
    output logic fire
);
    localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // A real termination in the firing cycle wins, so term suppresses fire.
    assign fire = active & ~term & (cnt_reg == FIRE_AT);

    // Count stalled strobe cycles; restart on termination, idle strobe or fire.
    always_comb begin
        cnt_next = cnt_reg;
        if (!active || term || fire) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/wb_vram_arbiter.sv
// Two-master Wishbone arbiter in front of the VRAM slave. Master 0 is the
// video line fetch, master 1 the CPU data port. Grant is held for a whole cyc;
// a watchdog converts a hung slave access into an err termination.
module wb_vram_arbiter
    import wb_vram_arbiter_pkg::*;
#(
    parameter int unsigned ADR_W       = ARB_ADR_W,
    parameter int unsigned DAT_W       = ARB_DAT_W,
    parameter int unsigned TIMEOUT     = ARB_TIMEOUT,
    parameter bit          M0_PRIORITY = 1'b1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_vram_arbiter_if.slave m0,
    wb_vram_arbiter_if.slave m1,
    wb_vram_arbiter_if.master s,
    output logic             m0_gnt_o,
    output logic             m1_gnt_o,
    output logic             tmo_o
);
    localparam int unsigned SEL_W = DAT_W / 8;

    arb_state_t       state_reg;
    arb_state_t       state_next;
    logic             last_gnt_reg;   // 0: master 0 granted last, 1: master 1
    logic             last_gnt_next;
    logic             m0_gnt_reg;
    logic             m1_gnt_reg;

    logic [1:0]       req_cyc;
    logic [1:0]       req_stb;
    logic [1:0]       gnt_vec;
    logic [1:0]       ack_vec;
    logic [1:0]       err_vec;
    logic [1:0]       rty_vec;

    logic             cyc_mux;
    logic             stb_mux;
    logic             we_mux;
    logic [ADR_W-1:0] adr_mux;
    logic [SEL_W-1:0] sel_mux;
    logic [DAT_W-1:0] dat_mux;

    logic             wd_active;
    logic             wd_term;
    logic             wd_fire;

    assign req_cyc = {m1.cyc, m0.cyc};
    assign req_stb = {m1.stb, m0.stb};
    assign gnt_vec = {m1_gnt_reg, m0_gnt_reg};

    // Next grant: arbitrate from IDLE, hand over directly when the owner drops cyc.
    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (req_cyc == 2'b11) begin
                    state_next = (M0_PRIORITY || last_gnt_reg) ? ARB_GNT0 : ARB_GNT1;
                end else if (req_cyc[0]) begin
                    state_next = ARB_GNT0;
                end else if (req_cyc[1]) begin
                    state_next = ARB_GNT1;
                end
            end
            ARB_GNT0: begin
                if (!req_cyc[0]) begin
                    state_next = req_cyc[1] ? ARB_GNT1 : ARB_IDLE;
                end
            end
            ARB_GNT1: begin
                if (!req_cyc[1]) begin
                    state_next = req_cyc[0] ? ARB_GNT0 : ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
        if (state_next == ARB_GNT0) begin
            last_gnt_next = 1'b0;
        end else if (state_next == ARB_GNT1) begin
            last_gnt_next = 1'b1;
        end
    end

    // Grant FSM with registered grant outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_reg    <= ARB_IDLE;
            last_gnt_reg <= 1'b1;
            m0_gnt_reg   <= 1'b0;
            m1_gnt_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
            m0_gnt_reg   <= (state_next == ARB_GNT0);
            m1_gnt_reg   <= (state_next == ARB_GNT1);
        end
    end

    // Forward the granted master's request to the slave; nothing in IDLE.
    always_comb begin
        cyc_mux = 1'b0;
        stb_mux = 1'b0;
        we_mux  = 1'b0;
        adr_mux = '0;
        sel_mux = '0;
        dat_mux = '0;
        case (state_reg)
            ARB_GNT0: begin
                cyc_mux = m0.cyc;
                stb_mux = m0.stb;
                we_mux  = m0.we;
                adr_mux = m0.adr;
                sel_mux = m0.sel;
                dat_mux = m0.dat_w;
            end
            ARB_GNT1: begin
                cyc_mux = m1.cyc;
                stb_mux = m1.stb;
                we_mux  = m1.we;
                adr_mux = m1.adr;
                sel_mux = m1.sel;
                dat_mux = m1.dat_w;
            end
            default: ;
        endcase
    end

    // Watchdog sees the unmasked strobe so the stb mask cannot feed back into fire.
    assign wd_active = cyc_mux & stb_mux;
    assign wd_term   = s.ack | s.err | s.rty;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .active   (wd_active),
        .term     (wd_term),
        .fire     (wd_fire)
    );

    assign s.cyc   = cyc_mux;
    assign s.stb   = stb_mux & ~wd_fire;
    assign s.we    = we_mux;
    assign s.adr   = adr_mux;
    assign s.sel   = sel_mux;
    assign s.dat_w = dat_mux;

    // Terminations go only to the granted master, gated by its own strobe.
    // Simultaneous ack/err from the slave pass through untouched.
    for (genvar gi = 0; gi < 2; gi++) begin : g_term
        assign ack_vec[gi] = s.ack & gnt_vec[gi] & req_stb[gi];
        assign err_vec[gi] = (s.err | wd_fire) & gnt_vec[gi] & req_stb[gi];
        assign rty_vec[gi] = s.rty & gnt_vec[gi] & req_stb[gi];
    end

    assign m0.ack   = ack_vec[0];
    assign m0.err   = err_vec[0];
    assign m0.rty   = rty_vec[0];
    assign m1.ack   = ack_vec[1];
    assign m1.err   = err_vec[1];
    assign m1.rty   = rty_vec[1];
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;

    assign m0_gnt_o = m0_gnt_reg;
    assign m1_gnt_o = m1_gnt_reg;
    assign tmo_o    = wd_fire;

endmodule

// File: tb/tb_wb_vram_arbiter.sv
// Directed bench for wb_vram_arbiter: a per-cycle vector table on a
// fixed-priority instance, plus hand sequences for bursts, watchdog,
// async reset and round-robin on a second instance.
module tb_wb_vram_arbiter;
    import wb_vram_arbiter_pkg::*;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam logic [31:0] M1_ADR = 32'h0000_1000;
    localparam int          NVEC   = 17;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;

    wb_vram_arbiter_if #(.ADR_W(AW), .DAT_W(DW)) a_m0 ();
    wb_vram_arbiter_if #(.ADR_W(AW), .DAT_W(DW)) a_m1 ();
    wb_vram_arbiter_if #(.ADR_W(AW), .DAT_W(DW)) a_s ();
    wb_vram_arbiter_if #(.ADR_W(AW), .DAT_W(DW)) b_m0 ();
    wb_vram_arbiter_if #(.ADR_W(AW), .DAT_W(DW)) b_m1 ();
    wb_vram_arbiter_if #(.ADR_W(AW), .DAT_W(DW)) b_s ();

    logic a_m0_gnt, a_m1_gnt, a_tmo;
    logic b_m0_gnt, b_m1_gnt, b_tmo;

    wb_vram_arbiter #(.ADR_W(AW), .DAT_W(DW), .TIMEOUT(8), .M0_PRIORITY(1'b1)) dut_a (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .m0       (a_m0),
        .m1       (a_m1),
        .s        (a_s),
        .m0_gnt_o (a_m0_gnt),
        .m1_gnt_o (a_m1_gnt),
        .tmo_o    (a_tmo)
    );

    wb_vram_arbiter #(.ADR_W(AW), .DAT_W(DW), .TIMEOUT(8), .M0_PRIORITY(1'b0)) dut_b (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .m0       (b_m0),
        .m1       (b_m1),
        .s        (b_s),
        .m0_gnt_o (b_m0_gnt),
        .m1_gnt_o (b_m1_gnt),
        .tmo_o    (b_tmo)
    );

    typedef struct {
        logic [3:0]  req;      // {m0_cyc, m0_stb, m1_cyc, m1_stb}
        logic [2:0]  term;     // slave {ack, err, rty}
        logic [10:0] exp_out;  // {s_cyc, s_stb, gnt0, gnt1, tmo, m0 a/e/r, m1 a/e/r}
        logic [31:0] exp_adr;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [3:0] req, input logic [2:0] term,
                                input logic [1:0] cs, input logic [1:0] g, input logic tmo,
                                input logic [2:0] t0, input logic [2:0] t1, input logic [31:0] adr);
        vec_t v;
        v.req     = req;
        v.term    = term;
        v.exp_out = {cs, g, tmo, t0, t1};
        v.exp_adr = adr;
        return v;
    endfunction

    function automatic logic [10:0] obs_a();
        return {a_s.cyc, a_s.stb, a_m0_gnt, a_m1_gnt, a_tmo,
                a_m0.ack, a_m0.err, a_m0.rty, a_m1.ack, a_m1.err, a_m1.rty};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic set_a(input logic [3:0] req, input logic [2:0] term);
        {a_m0.cyc, a_m0.stb, a_m1.cyc, a_m1.stb} = req;
        {a_s.ack, a_s.err, a_s.rty} = term;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int ok_beats;
        logic fire;
        logic [1:0] g;

        vecs[0]  = mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 3'b000, 3'b000, 32'h0);
        vecs[1]  = mk(4'b1100, 3'b000, 2'b00, 2'b00, 1'b0, 3'b000, 3'b000, 32'h0);
        vecs[2]  = mk(4'b1100, 3'b000, 2'b11, 2'b10, 1'b0, 3'b000, 3'b000, VRAM_BASE);
        vecs[3]  = mk(4'b1100, 3'b100, 2'b11, 2'b10, 1'b0, 3'b100, 3'b000, VRAM_BASE);
        vecs[4]  = mk(4'b0000, 3'b000, 2'b00, 2'b10, 1'b0, 3'b000, 3'b000, VRAM_BASE);
        vecs[5]  = mk(4'b0011, 3'b100, 2'b00, 2'b00, 1'b0, 3'b000, 3'b000, 32'h0);
        vecs[6]  = mk(4'b0011, 3'b001, 2'b11, 2'b01, 1'b0, 3'b000, 3'b001, M1_ADR);
        vecs[7]  = mk(4'b0011, 3'b110, 2'b11, 2'b01, 1'b0, 3'b000, 3'b110, M1_ADR);
        vecs[8]  = mk(4'b1110, 3'b100, 2'b10, 2'b01, 1'b0, 3'b000, 3'b000, M1_ADR);
        vecs[9]  = mk(4'b1100, 3'b000, 2'b00, 2'b01, 1'b0, 3'b000, 3'b000, M1_ADR);
        vecs[10] = mk(4'b1100, 3'b100, 2'b11, 2'b10, 1'b0, 3'b100, 3'b000, VRAM_BASE);
        vecs[11] = mk(4'b1111, 3'b100, 2'b11, 2'b10, 1'b0, 3'b100, 3'b000, VRAM_BASE);
        vecs[12] = mk(4'b0000, 3'b000, 2'b00, 2'b10, 1'b0, 3'b000, 3'b000, VRAM_BASE);
        vecs[13] = mk(4'b1111, 3'b000, 2'b00, 2'b00, 1'b0, 3'b000, 3'b000, 32'h0);
        vecs[14] = mk(4'b1111, 3'b010, 2'b11, 2'b10, 1'b0, 3'b010, 3'b000, VRAM_BASE);
        vecs[15] = mk(4'b0000, 3'b000, 2'b00, 2'b10, 1'b0, 3'b000, 3'b000, VRAM_BASE);
        vecs[16] = mk(4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 3'b000, 3'b000, 32'h0);

        a_m0.we = 1'b0; a_m0.adr = VRAM_BASE; a_m0.sel = 4'hf; a_m0.dat_w = 32'h0;
        a_m1.we = 1'b0; a_m1.adr = M1_ADR;    a_m1.sel = 4'hf; a_m1.dat_w = 32'h0;
        a_s.dat_r = 32'h1234_5678;
        b_m0.cyc = 1'b0; b_m0.stb = 1'b0; b_m0.we = 1'b0; b_m0.adr = VRAM_BASE;
        b_m0.sel = 4'hf; b_m0.dat_w = 32'h0;
        b_m1.cyc = 1'b0; b_m1.stb = 1'b0; b_m1.we = 1'b0; b_m1.adr = M1_ADR;
        b_m1.sel = 4'hf; b_m1.dat_w = 32'h0;
        b_s.ack = 1'b0; b_s.err = 1'b0; b_s.rty = 1'b0; b_s.dat_r = 32'h0;

        // Reset: requests and slave acks present, yet nothing may come out.
        set_a(4'b1111, 3'b100);
        #2;
        check("reset_outputs", 128'({obs_a(), a_s.adr}), 128'({11'b0, 32'h0}));
        check("reset_dat_pass", 128'(a_m0.dat_r), 128'(32'h1234_5678));
        set_a(4'b0000, 3'b000);
        tick();
        tick();
        wb_rst_i = 1'b1;

        // Per-cycle vector table on the fixed-priority instance.
        for (int i = 0; i < NVEC; i++) begin
            set_a(vecs[i].req, vecs[i].term);
            #4;
            check($sformatf("vec%0d", i), 128'({obs_a(), a_s.adr}),
                  128'({vecs[i].exp_out, vecs[i].exp_adr}));
            tick();
        end

        // 160-beat m0 burst with m1 waiting, then direct handover to the m1 write.
        a_m1.we = 1'b1;
        a_m1.dat_w = 32'hdead_beef;
        set_a(4'b1111, 3'b000);
        #4;
        check("burst_idle", 128'({a_m0_gnt, a_m1_gnt, a_s.cyc}), 128'(3'b000));
        tick();
        ok_beats = 0;
        for (int b = 0; b < 160; b++) begin
            set_a(4'b1111, 3'b100);
            #4;
            if (a_m0.ack === 1'b1 && a_m0_gnt === 1'b1 && a_m1.ack === 1'b0 && a_s.stb === 1'b1)
                ok_beats++;
            tick();
        end
        check("burst_beats", 128'(ok_beats), 128'(160));
        set_a(4'b0011, 3'b000);
        #4;
        check("burst_release", 128'({a_m0_gnt, a_m1_gnt, a_s.cyc}), 128'(3'b100));
        tick();
        set_a(4'b0011, 3'b100);
        #4;
        check("handover_write",
              128'({a_m1_gnt, a_s.cyc, a_s.stb, a_s.we, a_m1.ack, a_m0.ack, a_s.dat_w, a_s.adr}),
              128'({1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'hdead_beef, M1_ADR}));
        tick();
        a_m1.we = 1'b0;
        set_a(4'b0000, 3'b000);
        tick();
        tick();

        // Watchdog fires on the 8th and again on the 16th stalled strobe cycle.
        set_a(4'b0011, 3'b000);
        tick();
        for (int k = 1; k <= 16; k++) begin
            #4;
            fire = (k == 8) || (k == 16);
            check($sformatf("wdog_strobe%0d", k), 128'({a_m1.err, a_tmo, a_s.stb, a_m1.ack}),
                  128'({fire, fire, ~fire, 1'b0}));
            tick();
        end
        set_a(4'b0000, 3'b000);
        tick();
        tick();

        // Ack arriving in the would-be firing cycle wins.
        set_a(4'b0011, 3'b000);
        tick();
        for (int k = 1; k <= 8; k++) begin
            set_a(4'b0011, (k == 8) ? 3'b100 : 3'b000);
            #4;
            if (k == 8)
                check("wdog_ack_wins", 128'({a_m1.ack, a_m1.err, a_tmo, a_s.stb}), 128'(4'b1001));
            tick();
        end
        set_a(4'b0000, 3'b000);
        tick();
        tick();

        // Async reset in the middle of an m0 burst.
        set_a(4'b1100, 3'b100);
        tick();
        tick();
        #2;
        wb_rst_i = 1'b0;
        #1;
        check("async_reset_drop", 128'({a_s.cyc, a_s.stb, a_m0_gnt, a_m0.ack}), 128'(4'b0000));
        @(posedge wb_clk_i);
        @(posedge wb_clk_i);
        #3;
        wb_rst_i = 1'b1;
        #1;
        check("after_reset_idle", 128'({a_m0_gnt, a_m1_gnt, a_s.cyc, a_s.stb}), 128'(4'b0000));
        @(posedge wb_clk_i);
        #2;
        check("after_reset_grant", 128'({a_m0_gnt, a_s.cyc}), 128'(2'b11));
        set_a(4'b0000, 3'b000);
        tick();
        tick();

        // Round-robin instance: simultaneous requests from IDLE alternate 0,1,0,1.
        for (int t = 0; t < 4; t++) begin
            b_m0.cyc = 1'b1; b_m0.stb = 1'b1;
            b_m1.cyc = 1'b1; b_m1.stb = 1'b1;
            b_s.ack = 1'b0;
            #4;
            check($sformatf("rr_idle%0d", t), 128'({b_m0_gnt, b_m1_gnt, b_s.cyc}), 128'(3'b000));
            tick();
            b_s.ack = 1'b1;
            #4;
            g = (t % 2 == 0) ? 2'b10 : 2'b01;
            check($sformatf("rr_grant%0d", t),
                  128'({b_m0_gnt, b_m1_gnt, b_m0.ack, b_m1.ack, b_tmo}), 128'({g, g, 1'b0}));
            tick();
            b_m0.cyc = 1'b0; b_m0.stb = 1'b0;
            b_m1.cyc = 1'b0; b_m1.stb = 1'b0;
            b_s.ack = 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
